// File: rtl/ir_pkg.sv
// Shared state encoding and NEC timing constants for the IR transmit sequencer.
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_GAP
    } ir_state_e;

    localparam int unsigned NEC_LEAD_MARK  = 16;
    localparam int unsigned NEC_LEAD_SPACE = 8;
    localparam int unsigned NEC_RPT_SPACE  = 4;
    localparam int unsigned NEC_ONE_SPACE  = 3;
    localparam int unsigned NEC_BITS       = 32;

    // Unit counter must hold the longest single state (16 units).
    localparam int unsigned UNIT_W = 5;
    localparam int unsigned BIT_W  = $clog2(NEC_BITS);

    // Bit 0 of the word is the first bit on air (addr[0]).
    function automatic logic [NEC_BITS-1:0] nec_frame_word(input logic [7:0] addr,
                                                           input logic [7:0] cmd);
        return {~cmd, cmd, ~addr, addr};
    endfunction

endpackage

// File: rtl/ir_nec_tx_sequencer_if.sv
// Request handshake between the IR command source and the NEC frame sequencer.
interface ir_nec_tx_sequencer_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_addr;
    logic [7:0] tx_cmd;
    logic       tx_repeat;

    modport master (output tx_valid, tx_addr, tx_cmd, tx_repeat, input tx_ready);
    modport slave  (input tx_valid, tx_addr, tx_cmd, tx_repeat, output tx_ready);
endinterface

// File: rtl/ir_unit_timer.sv
// Prescaler producing one unit_tick per NEC unit, plus a per-state unit counter
// that flags the last tick of a state lasting target_i units.
module ir_unit_timer
    import ir_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 28125
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart_i,
    input  logic [UNIT_W-1:0] target_i,
    output logic              unit_tick_o,
    output logic              expired_o
);

    localparam int unsigned PRESC_W = $clog2(TICK_CYCLES);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [UNIT_W-1:0]  units_q, units_d;

    assign unit_tick_o = (presc_q == PRESC_W'(TICK_CYCLES - 1));
    assign expired_o   = unit_tick_o && (units_q == target_i - UNIT_W'(1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        presc_d = presc_q + PRESC_W'(1);
        units_d = units_q;
        if (restart_i) begin
            presc_d = '0;
            units_d = '0;
        end else if (unit_tick_o) begin
            presc_d = '0;
            units_d = units_q + UNIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            presc_q <= '0;
            units_q <= '0;
        end else begin
            presc_q <= presc_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/ir_nec_tx_sequencer.sv
// NEC frame scheduler: sequences carrier_en through leader, 32 data bits, stop mark
// and frame gap for each accepted command or repeat request.
module ir_nec_tx_sequencer
    import ir_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 28125,
    parameter int unsigned FRAME_UNITS = 192
) (
    input  logic                   clk,
    input  logic                   reset,
    ir_nec_tx_sequencer_if.slave   tx,
    output logic                   carrier_en,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned FRAME_W = $clog2(FRAME_UNITS + 1);

    ir_state_e             state_q;
    logic                  carrier_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  rpt_q;
    logic [NEC_BITS-1:0]   shift_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [FRAME_W-1:0]    frame_q;

    logic                  unit_tick;
    logic                  expired;
    logic                  restart;
    logic [UNIT_W-1:0]     target;

    // Timer is held cleared while idle and restarted on every timed state change.
    assign restart = (state_q == ST_IDLE) || (expired && (state_q != ST_GAP));

    always_comb begin
        target = UNIT_W'(1);
        case (state_q)
            ST_LEAD_MARK:  target = UNIT_W'(NEC_LEAD_MARK);
            ST_LEAD_SPACE: target = rpt_q ? UNIT_W'(NEC_RPT_SPACE) : UNIT_W'(NEC_LEAD_SPACE);
            ST_BIT_SPACE:  target = shift_q[0] ? UNIT_W'(NEC_ONE_SPACE) : UNIT_W'(1);
            default:       target = UNIT_W'(1);
        endcase
    end

    ir_unit_timer #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .restart_i   (restart),
        .target_i    (target),
        .unit_tick_o (unit_tick),
        .expired_o   (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            carrier_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            rpt_q     <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
        end else begin
            done_q <= 1'b0;
            // Frame counter runs on unit ticks from accept, whatever the state.
            if ((state_q != ST_IDLE) && unit_tick) frame_q <= frame_q + FRAME_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (tx.tx_valid && ready_q) begin
                        shift_q   <= nec_frame_word(tx.tx_addr, tx.tx_cmd);
                        rpt_q     <= tx.tx_repeat;
                        bit_cnt_q <= '0;
                        frame_q   <= '0;
                        ready_q   <= 1'b0;
                        carrier_q <= 1'b1;
                        state_q   <= ST_LEAD_MARK;
                    end
                end
                ST_LEAD_MARK: if (expired) begin
                    carrier_q <= 1'b0;
                    state_q   <= ST_LEAD_SPACE;
                end
                ST_LEAD_SPACE: if (expired) begin
                    carrier_q <= 1'b1;
                    state_q   <= rpt_q ? ST_STOP_MARK : ST_BIT_MARK;
                end
                ST_BIT_MARK: if (expired) begin
                    carrier_q <= 1'b0;
                    state_q   <= ST_BIT_SPACE;
                end
                ST_BIT_SPACE: if (expired) begin
                    shift_q   <= shift_q >> 1;
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    carrier_q <= 1'b1;
                    state_q   <= (bit_cnt_q == BIT_W'(NEC_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
                end
                ST_STOP_MARK: if (expired) begin
                    carrier_q <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= ST_GAP;
                end
                ST_GAP: if (unit_tick && (frame_q == FRAME_W'(FRAME_UNITS - 1))) begin
                    frame_q <= '0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    carrier_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_ready = ready_q;
    assign carrier_en  = carrier_q;
    assign busy        = ~ready_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ir_nec_tx_sequencer.sv
// Self-checking bench: table rows, random frames, back-to-back and mid-frame reset,
// all compared against a segment-list model of the NEC waveform.
module tb_ir_nec_tx_sequencer;

    localparam int TICK       = 4;
    localparam int FRAME      = 192;
    localparam int FRAME_CLKS = TICK * FRAME;
    localparam int WIN        = FRAME_CLKS + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  cmd;
        logic        rpt;
        logic [31:0] word;
        int          high;
        int          done_t;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic carrier_en, busy, done;

    ir_nec_tx_sequencer_if tx_bus ();

    ir_nec_tx_sequencer #(
        .TICK_CYCLES (TICK),
        .FRAME_UNITS (FRAME)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx         (tx_bus),
        .carrier_en (carrier_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int last_acc = 0;

    logic cap_car [1:WIN];
    logic cap_rdy [1:WIN];
    logic cap_done[1:WIN];
    logic cap_busy[1:WIN];
    logic exp_car [1:WIN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Expected carrier built from the NEC segment rules: (level, units) pairs expanded to clocks.
    task automatic build_model(input logic [7:0] a, input logic [7:0] c, input logic r,
                               output int done_t, output int high, output logic [31:0] word);
        int          seg_len[$];
        logic        seg_lvl[$];
        logic [31:0] w;
        int          t;
        w = {~c, c, ~a, a};
        seg_lvl.push_back(1'b1); seg_len.push_back(16);
        seg_lvl.push_back(1'b0); seg_len.push_back(r ? 4 : 8);
        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                seg_lvl.push_back(1'b1); seg_len.push_back(1);
                seg_lvl.push_back(1'b0); seg_len.push_back(w[i] ? 3 : 1);
            end
        end
        seg_lvl.push_back(1'b1); seg_len.push_back(1);
        for (int k = 1; k <= WIN; k++) exp_car[k] = 1'b0;
        t    = 1;
        high = 0;
        for (int s = 0; s < seg_len.size(); s++) begin
            for (int k = 0; k < seg_len[s] * TICK; k++) begin
                exp_car[t] = seg_lvl[s];
                if (seg_lvl[s]) high++;
                t++;
            end
        end
        done_t = t;
        word   = r ? 32'h0 : w;
    endtask

    task automatic drive_req(input logic [7:0] a, input logic [7:0] c, input logic r);
        tx_bus.tx_addr   = a;
        tx_bus.tx_cmd    = c;
        tx_bus.tx_repeat = r;
        tx_bus.tx_valid  = 1'b1;
    endtask

    task automatic capture_frame(input string tag, input bit hold, input bit drop_end,
                                 input bit use_tbl, input vec_t tv);
        int          n;
        logic [7:0]  a, c;
        logic        r;
        int          m_done, m_high;
        logic [31:0] m_word, dec;
        int          meas_high, meas_done, done_cnt, meas_rdy;
        int          mis_car, mis_rdy, mis_busy;
        int          runs[$];
        int          run_len;
        n = 0;
        while (!(tx_bus.tx_ready === 1'b1 && tx_bus.tx_valid === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.accept: no accept within 2000 cycles, expected tx_ready", tag);
            return;
        end
        a = tx_bus.tx_addr;
        c = tx_bus.tx_cmd;
        r = tx_bus.tx_repeat;
        @(posedge clk);
        last_acc = cyc;
        for (int t = 1; t <= WIN; t++) begin
            @(negedge clk);
            cap_car[t]  = carrier_en;
            cap_rdy[t]  = tx_bus.tx_ready;
            cap_done[t] = done;
            cap_busy[t] = busy;
            if (hold) begin
                if (t == 1) tx_bus.tx_cmd = 8'($urandom);
                if (drop_end && t == FRAME_CLKS) tx_bus.tx_valid = 1'b0;
            end else if (t < FRAME_CLKS) begin
                tx_bus.tx_addr   = 8'($urandom);
                tx_bus.tx_cmd    = 8'($urandom);
                tx_bus.tx_repeat = 1'($urandom_range(0, 1));
                tx_bus.tx_valid  = 1'($urandom_range(0, 1));
            end else begin
                tx_bus.tx_valid = 1'b0;
            end
        end

        build_model(a, c, r, m_done, m_high, m_word);
        meas_high = 0; meas_done = 0; done_cnt = 0; meas_rdy = 0;
        mis_car = 0; mis_rdy = 0; mis_busy = 0;
        for (int t = 1; t <= WIN; t++) begin
            if (cap_car[t]) meas_high++;
            if (cap_done[t]) begin
                done_cnt++;
                if (meas_done == 0) meas_done = t;
            end
            if (cap_rdy[t] && meas_rdy == 0) meas_rdy = t;
            if (cap_car[t] !== exp_car[t]) mis_car++;
            if (cap_rdy[t] !== (t >= WIN)) mis_rdy++;
            if (cap_busy[t] !== ~cap_rdy[t]) mis_busy++;
        end
        // Decode the captured waveform by run lengths: a long space is a 1.
        run_len = 1;
        for (int t = 2; t <= WIN; t++) begin
            if (cap_car[t] === cap_car[t-1]) run_len++;
            else begin
                runs.push_back(run_len);
                run_len = 1;
            end
        end
        runs.push_back(run_len);
        dec = '0;
        for (int i = 0; i < 32; i++)
            if (3 + 2 * i < runs.size()) dec[i] = (runs[3 + 2 * i] > 2 * TICK);

        check({tag, ".carrier_wave_bad_cycles"}, mis_car, 0);
        check({tag, ".ready_wave_bad_cycles"}, mis_rdy, 0);
        check({tag, ".busy_vs_ready_bad_cycles"}, mis_busy, 0);
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".done_cycle"}, meas_done, m_done);
        check({tag, ".ready_return_cycle"}, meas_rdy, WIN);
        check({tag, ".carrier_high_clks"}, meas_high, m_high);
        if (!r) check({tag, ".decoded_word"}, dec, m_word);
        if (use_tbl) begin
            check({tag, ".tbl_high_clks"}, meas_high, tv.high);
            check({tag, ".tbl_done_cycle"}, meas_done, tv.done_t);
            if (!tv.rpt) check({tag, ".tbl_word"}, dec, tv.word);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[4];
        vec_t        none;
        int          acc_prev;
        int          m_done, m_high;
        logic [31:0] m_word;
        int          cnt_done, cnt_car;

        vecs[0] = '{addr: 8'h00, cmd: 8'h00, rpt: 1'b0, word: 32'hFF00FF00, high: 196, done_t: 485};
        vecs[1] = '{addr: 8'h04, cmd: 8'h08, rpt: 1'b0, word: 32'hF708FB04, high: 196, done_t: 485};
        vecs[2] = '{addr: 8'h00, cmd: 8'h00, rpt: 1'b1, word: 32'h0,        high: 68,  done_t: 85};
        vecs[3] = '{addr: 8'hA5, cmd: 8'h3C, rpt: 1'b0, word: 32'hC33C5AA5, high: 196, done_t: 485};
        none    = '{addr: 8'h00, cmd: 8'h00, rpt: 1'b0, word: 32'h0,        high: 0,   done_t: 0};

        tx_bus.tx_valid  = 1'b0;
        tx_bus.tx_addr   = 8'h00;
        tx_bus.tx_cmd    = 8'h00;
        tx_bus.tx_repeat = 1'b0;

        repeat (3) @(negedge clk);
        check("reset.carrier_en", carrier_en, 1'b0);
        check("reset.tx_ready", tx_bus.tx_ready, 1'b1);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(vecs[i].addr, vecs[i].cmd, vecs[i].rpt);
            capture_frame($sformatf("vec%0d", i), 1'b0, 1'b0, 1'b1, vecs[i]);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
            capture_frame($sformatf("rand%0d", i), 1'b0, 1'b0, 1'b0, none);
        end

        // Held tx_valid: three accepts one frame period plus one cycle apart.
        @(negedge clk);
        drive_req(8'($urandom), 8'($urandom), 1'b0);
        capture_frame("b2b0", 1'b1, 1'b0, 1'b0, none);
        acc_prev = last_acc;
        capture_frame("b2b1", 1'b1, 1'b0, 1'b0, none);
        check("b2b.gap01", last_acc - acc_prev, WIN);
        acc_prev = last_acc;
        capture_frame("b2b2", 1'b1, 1'b1, 1'b0, none);
        check("b2b.gap12", last_acc - acc_prev, WIN);
        repeat (3) @(negedge clk);
        check("b2b.idle_after_release", busy, 1'b0);

        // Reset during the space of bit 5 (addr=0 puts it at cycles 141..144).
        build_model(8'h00, 8'h00, 1'b0, m_done, m_high, m_word);
        @(negedge clk);
        check("rst.ready_before", tx_bus.tx_ready, 1'b1);
        drive_req(8'h00, 8'h00, 1'b0);
        @(posedge clk);
        for (int t = 1; t <= 142; t++) begin
            @(negedge clk);
            if (t == 1) tx_bus.tx_valid = 1'b0;
            if (t == 140) check("rst.bit5_mark", carrier_en, exp_car[140]);
            if (t == 141) check("rst.bit5_space", carrier_en, exp_car[141]);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst.carrier_en", carrier_en, 1'b0);
        check("rst.tx_ready", tx_bus.tx_ready, 1'b1);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt_done = 0;
        cnt_car  = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (carrier_en) cnt_car++;
        end
        check("rst.no_done_after", cnt_done, 0);
        check("rst.no_carrier_after", cnt_car, 0);
        @(negedge clk);
        drive_req(8'h3A, 8'hC5, 1'b0);
        capture_frame("post_rst", 1'b0, 1'b0, 1'b0, none);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
